hilo_md_unit: RTL and testbench

//  Parametrised HI/LO unit: HI/LO register pair with integrated pipelined multiplier and iterative

---
 rtl/hilo_pkg.sv | 29 ++
 rtl/div_iter.sv | 68 ++++++
 rtl/hilo_md_unit.sv | 151 +++++++++++++++
 tb/tb_hilo_md_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared opcodes, FSM encoding and divide-by-zero constants for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Divide by zero fills LO with this bit; HI takes the dividend unchanged.
  localparam logic DIV0_LO_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_RUN,
    ST_DIV_FIX
  } state_t;

  function automatic logic is_mul(input logic [2:0] code);
    return (code == OP_MULT) || (code == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] code);
    return (code == OP_DIV) || (code == OP_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider on operand magnitudes: one quotient bit per cycle, WIDTH cycles.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH:0]   partial, diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    partial = {rem_q, quo_q[WIDTH-1]};
    diff    = partial - {1'b0, dvs_q};
  end

  assign last      = running && (cnt == CW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt     <= '0;
      running <= 1'b0;
      valid   <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
      valid   <= 1'b0;
    end else if (start) begin
      rem_q   <= '0;
      quo_q   <= dividend;
      dvs_q   <= divisor;
      cnt     <= CW'(WIDTH);
      running <= 1'b1;
      valid   <= 1'b0;
    end else if (running) begin
      if (!diff[WIDTH]) begin
        rem_q <= diff[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= partial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
      if (last) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO register pair with a pipelined multiplier and an iterative divider behind a valid/ready issue port.
module hilo_md_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 1);

  state_t state, state_nx;

  logic               accept, sdiv, div_start, div_valid, div_last;
  logic               wr_en, div_zero, q_neg, r_neg;
  logic [1:0]         mul_cnt;
  logic [WIDTH-1:0]   a_r, a_mag, b_mag, div_q, div_r;
  logic [2*WIDTH-1:0] wr_val;
  logic [2*WIDTH-1:0] mul_pipe [MUL_STAGES];

  // Operands are sign- or zero-extended to 2*WIDTH; the low 2*WIDTH product bits are exact either way.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic sgn);
    logic [2*WIDTH-1:0] ae, be;
    ae = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    be = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ae * be;
  endfunction

  assign accept   = op_valid && op_ready && !flush;
  assign op_ready = (state == ST_IDLE);
  assign busy     = !op_ready;
  assign sdiv     = (op == OP_DIV);
  assign a_mag    = (sdiv && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_mag    = (sdiv && src_b[WIDTH-1]) ? -src_b : src_b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .valid     (div_valid),
    .last      (div_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    wr_val    = '0;
    div_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul(op)) begin
          state_nx = ST_MUL;
        end else if (accept && is_div(op)) begin
          state_nx  = ST_DIV_RUN;
          div_start = 1'b1;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nx = ST_IDLE;
        end else if (mul_cnt == MUL_LAST) begin
          state_nx = ST_IDLE;
          wr_en    = 1'b1;
          wr_val   = mul_pipe[MUL_STAGES-1];
        end
      end
      ST_DIV_RUN: begin
        if (flush)         state_nx = ST_IDLE;
        else if (div_last) state_nx = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        state_nx = ST_IDLE;
        if (!flush && div_valid) begin
          wr_en = 1'b1;
          if (div_zero) wr_val = {a_r, {WIDTH{DIV0_LO_BIT}}};
          else          wr_val = {r_neg ? -div_r : div_r, q_neg ? -div_q : div_q};
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Product enters the pipe at acceptance, so the HI/LO write lands MUL_STAGES edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_STAGES; i++) mul_pipe[i] <= '0;
    end else begin
      if (accept && is_mul(op)) mul_pipe[0] <= mul_full(src_a, src_b, op == OP_MULT);
      for (int i = 1; i < MUL_STAGES; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt  <= '0;
      done     <= 1'b0;
      a_r      <= '0;
      div_zero <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      done    <= wr_en;
      mul_cnt <= (state == ST_MUL) ? mul_cnt + 2'd1 : 2'd0;
      if (div_start) begin
        a_r      <= src_a;
        div_zero <= (src_b == '0);
        q_neg    <= sdiv && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        r_neg    <= sdiv && src_a[WIDTH-1];
      end
    end
  end

  // MTHI/MTLO are only accepted in IDLE, so they never collide with a MULT/DIV result write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wr_en) begin
      {hi_o, lo_o} <= wr_val;
    end else if (accept && op == OP_MTHI) begin
      hi_o <= src_a;
    end else if (accept && op == OP_MTLO) begin
      lo_o <= src_a;
    end
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed bench for hilo_md_unit: MTHI/MTLO, MULT/MULTU, DIV/DIVU corner cases, flush and async reset.
module tb_hilo_md_unit;
  import hilo_pkg::*;

  logic        clk, rst, op_valid, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        op_ready, busy, done;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;
  int n;

  hilo_md_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for exactly one edge (the acceptance edge when the unit is idle).
  task automatic applyStimulus(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = code;
    src_a    = a;
    src_b    = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; flush = 1'b0; op = '0; src_a = '0; src_b = '0;
    tick();
    rst = 1'b0;
    checkOutput("reset_hilo", {hi_o, lo_o}, 64'h0);
    checkOutput("reset_ready", {61'h0, op_ready, busy, done}, 64'h4);

    applyStimulus(OP_MTHI, 32'h1234_5678, 32'h0);
    checkOutput("mthi", {hi_o, lo_o}, 64'h1234_5678_0000_0000);
    applyStimulus(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    checkOutput("mtlo", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    checkOutput("mt_no_busy_done", {62'h0, busy, done}, 64'h0);

    applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    checkOutput("mult_busy_e0", {63'h0, busy}, 64'h1);
    tick();
    checkOutput("mult_hold_e1", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    tick();
    checkOutput("mult_result", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    checkOutput("mult_done", {62'h0, busy, done}, 64'h1);
    tick();
    checkOutput("mult_done_pulse", {63'h0, done}, 64'h0);

    applyStimulus(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    tick(); tick();
    checkOutput("multu_result", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle(n);
    checkOutput("div_latency", 64'(n), 64'd33);
    checkOutput("div_neg_result", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("div_done", {63'h0, done}, 64'h1);

    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    src_a = 32'd999; src_b = 32'd3;
    waitIdle(n);
    checkOutput("divu_result", {hi_o, lo_o}, {32'd2, 32'd14});

    applyStimulus(OP_DIV, 32'd5, 32'd0);
    waitIdle(n);
    checkOutput("div_by_zero", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});

    applyStimulus(OP_DIVU, 32'hFFFF_FFF0, 32'd0);
    waitIdle(n);
    checkOutput("divu_by_zero", {hi_o, lo_o}, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(n);
    checkOutput("div_min_neg1", {hi_o, lo_o}, {32'h0, 32'h8000_0000});

    $display("[TB] flush mid-DIVU with MTLO held while busy");
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    op_valid = 1'b1; op = OP_MTLO; src_a = 32'hDEAD_BEEF;
    for (int i = 0; i < 9; i++) tick();
    checkOutput("mtlo_ignored_busy", {hi_o, lo_o}, {32'h0, 32'h8000_0000});
    checkOutput("still_busy", {63'h0, busy}, 64'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_idle", {62'h0, op_ready, busy}, 64'h2);
    checkOutput("flush_no_write", {hi_o, lo_o}, {32'h0, 32'h8000_0000});
    checkOutput("flush_no_done", {63'h0, done}, 64'h0);
    tick();
    op_valid = 1'b0;
    checkOutput("mtlo_after_ready", {hi_o, lo_o}, {32'h0, 32'hDEAD_BEEF});
    checkOutput("flush_no_done_late", {63'h0, done}, 64'h0);

    applyStimulus(OP_MULT, 32'd2, 32'd3);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_write_cycle", {hi_o, lo_o}, {32'h0, 32'hDEAD_BEEF});
    checkOutput("flush_write_idle", {62'h0, busy, done}, 64'h0);
    tick();
    checkOutput("flush_write_no_done", {63'h0, done}, 64'h0);

    flush = 1'b1;
    applyStimulus(OP_MTHI, 32'h0000_1111, 32'h0);
    flush = 1'b0;
    checkOutput("flush_idle_drop", {hi_o, lo_o}, {32'h0, 32'hDEAD_BEEF});

    $display("[TB] async reset mid-DIV");
    applyStimulus(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_hilo", {hi_o, lo_o}, 64'h0);
    checkOutput("async_rst_ready", {61'h0, op_ready, busy, done}, 64'h4);
    #2 rst = 1'b0;
    tick();
    applyStimulus(OP_MULT, 32'd7, 32'd6);
    tick(); tick();
    checkOutput("mult_after_rst", {hi_o, lo_o}, 64'd42);
    checkOutput("mult_after_rst_done", {63'h0, done}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
